// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder for the load/store path. Accepts one request at a
//   time, waits WAIT_CYCLES, performs a byte/halfword/word access against an
//   internal word-organised RAM and returns a one-cycle response.
//
// Parameters
//   ADDR_WIDTH  - log2 of RAM depth in 32-bit words
//   WAIT_CYCLES - cycles spent in WAIT between acceptance and response (0 ok)
//
// Ports
//   clk, rst_n          - clock, synchronous active-low reset
//   req_valid/req_ready - request handshake (ready only in IDLE)
//   mem_read/mem_write  - load / store strobes
//   funct3              - size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, wdata         - byte address, low-aligned store data
//   rsp_valid           - one-cycle response strobe
//   rsp_rdata, rsp_err  - load result (0 for stores/errors), error flag
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               l_read;
  logic               l_write;
  logic [2:0]         l_funct3;
  logic [31:0]        l_addr;
  logic [31:0]        l_wdata;

  logic [31:0]        mem [DEPTH];

  // Access operands: live inputs in IDLE (so a zero-wait request can be
  // evaluated on its accept edge), latched copy otherwise.
  logic               e_read;
  logic               e_write;
  logic [2:0]         e_funct3;
  logic [31:0]        e_addr;
  logic [31:0]        e_wdata;

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]        word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [31:0]        load_data;
  logic [3:0]         lane_en;
  logic [31:0]        lane_data;
  logic               err;
  logic               go_resp;
  logic               commit;

  always_comb begin
    if (state == IDLE) begin
      e_read   = mem_read;
      e_write  = mem_write;
      e_funct3 = funct3;
      e_addr   = addr;
      e_wdata  = wdata;
    end else begin
      e_read   = l_read;
      e_write  = l_write;
      e_funct3 = l_funct3;
      e_addr   = l_addr;
      e_wdata  = l_wdata;
    end
  end

  // Request legality
  always_comb begin
    err = 1'b0;
    if (e_read == e_write)
      err = 1'b1;
    else if (e_read && (e_funct3 == 3'b011 || e_funct3[2:1] == 2'b11))
      err = 1'b1;
    else if (e_write && (e_funct3[2] || e_funct3[1:0] == 2'b11))
      err = 1'b1;
    if (e_funct3[1:0] == 2'b01 && e_addr[0])
      err = 1'b1;
    if (e_funct3[1:0] == 2'b10 && e_addr[1:0] != 2'b00)
      err = 1'b1;
    if ((e_addr >> (ADDR_WIDTH + 2)) != '0)
      err = 1'b1;
  end

  // Load path
  always_comb begin
    idx      = e_addr[ADDR_WIDTH+1:2];
    word     = mem[idx];
    byte_sel = word[{e_addr[1:0], 3'b000} +: 8];
    half_sel = e_addr[1] ? word[31:16] : word[15:0];
    case (e_funct3)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = word;
      3'b100:  load_data = {24'd0, byte_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = '0;
    endcase
  end

  // Store lane enables and replicated lane data
  always_comb begin
    case (e_funct3[1:0])
      2'b00: begin
        lane_en   = 4'b0001 << e_addr[1:0];
        lane_data = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = e_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{e_wdata[15:0]}};
      end
      default: begin
        lane_en   = 4'b1111;
        lane_data = e_wdata;
      end
    endcase
  end

  always_comb begin
    go_resp = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
              ((state == WAIT) && (cnt == '0));
    commit  = rst_n && go_resp && e_write && !err;
  end

  // RAM is not reset; a store is blocked when reset coincides with commit.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_en[i])
          mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      l_read    <= 1'b0;
      l_write   <= 1'b0;
      l_funct3  <= '0;
      l_addr    <= '0;
      l_wdata   <= '0;
    end else begin
      if (go_resp) begin
        state     <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (!err && e_read) ? load_data : '0;
      end
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_read    <= mem_read;
            l_write   <= mem_write;
            l_funct3  <= funct3;
            l_addr    <= addr;
            l_wdata   <= wdata;
            req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt != '0)
            cnt <= cnt - 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. One instance uses
//   WAIT_CYCLES=2 for the main scenarios, a second uses WAIT_CYCLES=0.
//   Expected results come from a byte-addressed memory model.
module tb_data_mem_responder;

  localparam int AW        = 10;
  localparam int RAM_BYTES = 4 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_mem_read, z_mem_write;
  logic [2:0]  z_funct3;
  logic [31:0] z_addr, z_wdata;
  logic        z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .mem_read(z_mem_read), .mem_write(z_mem_write), .funct3(z_funct3),
    .addr(z_addr), .wdata(z_wdata), .rsp_valid(z_rsp_valid),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int checks   = 0;
  int failures = 0;

  // Byte-addressed model of the RAM
  logic [7:0] ref_mem [RAM_BYTES];

  function automatic void ref_access(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] wd,
                                     output logic e, output logic [31:0] d);
    int size;
    logic [63:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    e = 1'b0;
    d = '0;
    if (rd == wr) e = 1'b1;
    else if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e = 1'b1;
    else if (wr && f3 > 3'd2) e = 1'b1;
    if (!e && (a % size) != 0) e = 1'b1;
    if (!e && a >= RAM_BYTES) e = 1'b1;
    if (!e) begin
      if (rd) begin
        v = '0;
        for (int k = 0; k < size; k++) v = v | (64'(ref_mem[a + k]) << (8 * k));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 1);
        d = v[31:0];
      end else begin
        for (int k = 0; k < size; k++) ref_mem[a + k] = wd[8*k +: 8];
      end
    end
  endfunction

  // Drives one request into u_dut, returns the response, latency (cycles
  // from accept edge to the rsp_valid cycle), busy cycles and model result.
  task automatic xact(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] got_d, output logic got_e,
                      output int lat, output int busy,
                      output logic [31:0] exp_d, output logic exp_e);
    int n;
    got_d = '0; got_e = 1'b0; lat = -1; busy = 0; n = 0;
    ref_access(rd, wr, f3, a, wd, exp_e, exp_d);
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout req_ready=%b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs to confirm the latched copy is used
    req_valid = 1'b0; mem_read = 1'($urandom); mem_write = 1'($urandom);
    funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (!req_ready) busy++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
      lat = -1;
      return;
    end
    if (!req_ready) busy++;
    got_d = rsp_rdata;
    got_e = rsp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 8;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rsp_valid); end
    if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rsp_err); end
    if (z_req_ready !== 1'b1) begin failures++; $display("FAIL rst_z_ready got=%b exp=1", z_req_ready); end
    if (z_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_z_valid got=%b exp=0", z_rsp_valid); end
    if (z_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_z_rdata got=%h exp=0", z_rsp_rdata); end
    if (z_rsp_err !== 1'b0) begin failures++; $display("FAIL rst_z_err got=%b exp=0", z_rsp_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [31:0] d, ed, a;
    logic e, ee;
    int lat, busy;
    for (int i = 0; i < 36; i++) begin
      a = (i < 32) ? 32'(4 * i) : 32'(4 * (1020 + i - 32));
      xact(1'b0, 1'b1, 3'b010, a, $urandom, d, e, lat, busy, ed, ee);
      checks++;
      if (e !== 1'b0) begin failures++; $display("FAIL init_err a=%h got=%b exp=0", a, e); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] d, ed;
    logic e, ee;
    int lat, busy;
    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, d, e, lat, busy, ed, ee);
    checks += 4;
    if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", lat); end
    if (e !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", e); end
    if (d !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", d); end
    if (busy !== 3) begin failures++; $display("FAIL sw_busy got=%0d exp=3", busy); end
    @(negedge clk);
    checks += 2;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_pulse got=%b exp=0", rsp_valid); end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL ready_after got=%b exp=1", req_ready); end

    xact(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, busy, ed, ee);
    checks += 3;
    if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", d); end
    if (lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    if (busy !== 3) begin failures++; $display("FAIL lw_busy got=%0d exp=3", busy); end

    xact(1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, d, e, lat, busy, ed, ee);
    xact(1'b0, 1'b1, 3'b000, 32'h11, 32'h000000F0, d, e, lat, busy, ed, ee);
    xact(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'h1122F044) begin failures++; $display("FAIL sb_merge got=%h exp=1122f044", d); end
    xact(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'hFFFFFFF0) begin failures++; $display("FAIL lb got=%h exp=fffffff0", d); end
    xact(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'h000000F0) begin failures++; $display("FAIL lbu got=%h exp=000000f0", d); end
    xact(1'b0, 1'b1, 3'b001, 32'h12, 32'h00008001, d, e, lat, busy, ed, ee);
    xact(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", d); end
    xact(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", d); end
  endtask

  task automatic test_errors();
    logic        t_rd [7] = '{1, 0, 1, 1, 1, 0, 0};
    logic        t_wr [7] = '{0, 1, 0, 1, 0, 1, 1};
    logic [2:0]  t_f3 [7] = '{3'b010, 3'b001, 3'b010, 3'b010, 3'b011, 3'b010, 3'b100};
    logic [31:0] t_a  [7] = '{32'h13, 32'h01, 32'h1000, 32'h10, 32'h10, 32'h1000, 32'h10};
    logic [31:0] t_rb [7] = '{32'h10, 32'h00, 32'h00, 32'h10, 32'h10, 32'h00, 32'h10};
    logic [31:0] d, ed;
    logic e, ee;
    int lat, busy;
    for (int i = 0; i < 7; i++) begin
      xact(t_rd[i], t_wr[i], t_f3[i], t_a[i], 32'hA5A5FFFF, d, e, lat, busy, ed, ee);
      checks += 2;
      if (e !== 1'b1) begin failures++; $display("FAIL err_flag case=%0d got=%b exp=1", i, e); end
      if (d !== 32'h0) begin failures++; $display("FAIL err_rdata case=%0d got=%h exp=0", i, d); end
      xact(1'b1, 1'b0, 3'b010, t_rb[i], 32'h0, d, e, lat, busy, ed, ee);
      checks++;
      if (d !== ed) begin failures++; $display("FAIL err_reread case=%0d got=%h exp=%h", i, d, ed); end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, a;
    logic e, ee, rd, wr;
    logic [2:0] f3;
    int lat, busy, r, k;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(9, 0);
      if (r == 0) a = 32'hFF0 + $urandom_range(15, 0);
      else if (r == 1) a = $urandom;
      else if (r == 2) a = 32'h1000 + $urandom_range(127, 0);
      else a = $urandom_range(127, 0);
      k = $urandom_range(9, 0);
      rd = (k == 0) || (k >= 2 && k < 6);
      wr = (k == 0) || (k >= 6);
      f3 = 3'($urandom);
      xact(rd, wr, f3, a, $urandom, d, e, lat, busy, ed, ee);
      checks += 3;
      if (d !== ed) begin failures++; $display("FAIL rnd_rdata i=%0d rd=%b wr=%b f3=%b a=%h got=%h exp=%h", i, rd, wr, f3, a, d, ed); end
      if (e !== ee) begin failures++; $display("FAIL rnd_err i=%0d rd=%b wr=%b f3=%b a=%h got=%b exp=%b", i, rd, wr, f3, a, e, ee); end
      if (lat !== 3) begin failures++; $display("FAIL rnd_latency i=%0d got=%0d exp=3", i, lat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, ed;
    logic e, ee;
    int lat, busy, seen;
    xact(1'b0, 1'b1, 3'b010, 32'h20, 32'hA5A55A5A, d, e, lat, busy, ed, ee);
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'hA5A55A5A) begin failures++; $display("FAIL mid_pre got=%h exp=a5a55a5a", d); end
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b010;
    addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    // reset lands on the edge that would otherwise commit the store
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks += 4;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", rsp_valid); end
    if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
    if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin failures++; $display("FAIL mid_err got=%b exp=0", rsp_err); end
    seen = 0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL mid_stray_rsp got=%0d exp=0", seen); end
    xact(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, d, e, lat, busy, ed, ee);
    checks++;
    if (d !== 32'hA5A55A5A) begin failures++; $display("FAIL mid_reread got=%h exp=a5a55a5a", d); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] zw;
    int accepts, rsps;
    zw = $urandom;
    @(negedge clk);
    checks++;
    if (z_req_ready !== 1'b1) begin failures++; $display("FAIL z_ready_idle got=%b exp=1", z_req_ready); end
    z_req_valid = 1'b1; z_mem_read = 1'b0; z_mem_write = 1'b1; z_funct3 = 3'b010;
    z_addr = 32'h4; z_wdata = zw;
    @(posedge clk);
    @(negedge clk);
    z_req_valid = 1'b0;
    checks += 3;
    if (z_rsp_valid !== 1'b1) begin failures++; $display("FAIL z_latency valid=%b exp=1", z_rsp_valid); end
    if (z_req_ready !== 1'b0) begin failures++; $display("FAIL z_busy got=%b exp=0", z_req_ready); end
    if (z_rsp_err !== 1'b0) begin failures++; $display("FAIL z_sw_err got=%b exp=0", z_rsp_err); end
    @(negedge clk);
    checks += 2;
    if (z_req_ready !== 1'b1) begin failures++; $display("FAIL z_ready_back got=%b exp=1", z_req_ready); end
    if (z_rsp_valid !== 1'b0) begin failures++; $display("FAIL z_pulse got=%b exp=0", z_rsp_valid); end
    // continuous requests: one accept every two cycles
    z_req_valid = 1'b1; z_mem_read = 1'b1; z_mem_write = 1'b0; z_funct3 = 3'b010; z_addr = 32'h4;
    accepts = 0; rsps = 0;
    for (int i = 0; i < 20; i++) begin
      if (z_req_ready) accepts++;
      if (z_rsp_valid) begin
        rsps++;
        checks++;
        if (z_rsp_rdata !== zw) begin failures++; $display("FAIL z_lw_data got=%h exp=%h", z_rsp_rdata, zw); end
      end
      @(negedge clk);
    end
    z_req_valid = 1'b0;
    checks += 2;
    if (accepts !== 10) begin failures++; $display("FAIL z_accepts got=%0d exp=10", accepts); end
    if (rsps !== 10) begin failures++; $display("FAIL z_rsps got=%0d exp=10", rsps); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    z_req_valid = 1'b0; z_mem_read = 1'b0; z_mem_write = 1'b0; z_funct3 = '0; z_addr = '0; z_wdata = '0;
    test_reset();
    test_init();
    test_directed();
    test_errors();
    test_random();
    test_reset_mid();
    test_zero_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
